rx_peak_window_reader: RTL and testbench

//  Downstream of rx_correlator_buff_unit. Detects each ping-pong buffer swap, reads the

---
 rtl/rx_peak_window_reader.sv | 154 +++++++++++++++
 tb/tb_rx_peak_window_reader.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_peak_window_reader.sv
// Reads each completed ping-pong half from BRAM, peak-aligned, and streams it on valid/ready.
// Optional peak-threshold gating is enabled by defining RX_PEAK_WIN_THRESH_EN.
//
// state   | meaning
// S_IDLE  | waiting for a buffer-flag toggle
// S_ISSUE | BRAM read enable asserted for sample k
// S_CAPT  | BRAM data arriving, registered onto osample
// S_HOLD  | osample valid, waiting for consumer ready
module rx_peak_window_reader #(
  parameter int RAM_BASE_ADDRESS = 0,
  parameter int WIN_LEN          = 128,
  parameter int PEAK_IDX         = 63
) (
  input  logic               crx_clk,
  input  logic               rrx_rst_n,
  input  logic               erx_en,
  input  logic               ibuff_flag,
  input  logic [6:0]         ipeak_pos,
  input  logic signed [31:0] iram_data_out,
  output logic               oram_r_enable,
  output logic [9:0]         oram_r_address,
  output logic signed [31:0] osample,
  output logic               osample_valid,
  input  logic               isample_ready,
  output logic               osample_first,
  output logic               osample_last,
  output logic [6:0]         opeak_pos,
  output logic               obusy,
  output logic               ooverrun
`ifdef RX_PEAK_WIN_THRESH_EN
  ,
  input  logic signed [31:0] ipeak_val,
  input  logic signed [31:0] ithreshold,
  output logic               odropped
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_CAPT, S_HOLD} state_t;

  localparam logic [9:0] C_BASE = 10'(RAM_BASE_ADDRESS);
  localparam logic [6:0] C_PEAK = 7'(PEAK_IDX);
  localparam logic [6:0] C_LAST = 7'(WIN_LEN - 1);

  state_t     r_state;
  logic       r_flag_d;
  logic       r_half_hi;
  logic [6:0] r_start;
  logic [6:0] r_k;

  logic       w_swap;
  logic       w_accept;
  logic [6:0] w_start_new;
  logic [6:0] w_k_next;

  assign w_swap      = ibuff_flag ^ r_flag_d;
  assign w_start_new = ipeak_pos - C_PEAK;
  assign w_k_next    = r_k + 7'd1;

`ifdef RX_PEAK_WIN_THRESH_EN
  assign w_accept = (ipeak_val > ithreshold);
`else
  assign w_accept = 1'b1;
`endif

  // Offset wraps inside the 128-entry half, so the window is circular around the peak.
  function automatic logic [9:0] f_addr(input logic half_hi, input logic [6:0] start,
                                        input logic [6:0] k);
    logic [6:0] off;
    off = start + k;
    return C_BASE + {2'b00, half_hi, off};
  endfunction

  always_ff @(posedge crx_clk or negedge rrx_rst_n) begin
    if (!rrx_rst_n) begin
      r_state        <= S_IDLE;
      r_flag_d       <= 1'b0;
      r_half_hi      <= 1'b0;
      r_start        <= '0;
      r_k            <= '0;
      oram_r_enable  <= 1'b0;
      oram_r_address <= '0;
      osample        <= '0;
      osample_valid  <= 1'b0;
      osample_first  <= 1'b0;
      osample_last   <= 1'b0;
      opeak_pos      <= '0;
      obusy          <= 1'b0;
      ooverrun       <= 1'b0;
`ifdef RX_PEAK_WIN_THRESH_EN
      odropped       <= 1'b0;
`endif
    end else begin
      r_flag_d      <= ibuff_flag;
      oram_r_enable <= 1'b0;
      ooverrun      <= 1'b0;
`ifdef RX_PEAK_WIN_THRESH_EN
      odropped      <= 1'b0;
`endif
      if (!erx_en) begin
        r_state       <= S_IDLE;
        osample_valid <= 1'b0;
        osample_first <= 1'b0;
        osample_last  <= 1'b0;
        obusy         <= 1'b0;
      end else begin
        if (w_swap && r_state != S_IDLE) ooverrun <= 1'b1;
        case (r_state)
          S_IDLE: begin
            if (w_swap && w_accept) begin
              // flag==1 means the lower half just completed
              r_half_hi      <= ~ibuff_flag;
              r_start        <= w_start_new;
              r_k            <= '0;
              opeak_pos      <= ipeak_pos;
              obusy          <= 1'b1;
              oram_r_enable  <= 1'b1;
              oram_r_address <= f_addr(~ibuff_flag, w_start_new, 7'd0);
              r_state        <= S_ISSUE;
            end
`ifdef RX_PEAK_WIN_THRESH_EN
            if (w_swap && !w_accept) odropped <= 1'b1;
`endif
          end
          S_ISSUE: r_state <= S_CAPT;
          S_CAPT: begin
            osample       <= iram_data_out;
            osample_valid <= 1'b1;
            osample_first <= (r_k == 7'd0);
            osample_last  <= (r_k == C_LAST);
            r_state       <= S_HOLD;
          end
          S_HOLD: begin
            if (isample_ready) begin
              osample_valid <= 1'b0;
              osample_first <= 1'b0;
              osample_last  <= 1'b0;
              if (r_k == C_LAST) begin
                obusy   <= 1'b0;
                r_state <= S_IDLE;
              end else begin
                r_k            <= w_k_next;
                oram_r_enable  <= 1'b1;
                oram_r_address <= f_addr(r_half_hi, r_start, w_k_next);
                r_state        <= S_ISSUE;
              end
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rx_peak_window_reader.sv
// Self-checking bench for rx_peak_window_reader: table vectors, random windows against a
// queue-based reference model, plus overrun, enable and reset sequences.
module tb_rx_peak_window_reader;

  localparam int BASE = 256;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               en = 1'b1;
  logic               flag = 1'b0;
  logic [6:0]         pos = '0;
  logic signed [31:0] rdata = '0;
  logic               ren;
  logic [9:0]         raddr;
  logic signed [31:0] samp;
  logic               valid;
  logic               ready = 1'b1;
  logic               first, last, busy, ovr;
  logic [6:0]         peak_o;
`ifdef RX_PEAK_WIN_THRESH_EN
  logic signed [31:0] pval = 32'sd2000;
  logic signed [31:0] thr  = 32'sd1000;
  logic               dropped;
  int                 n_drop = 0;
`endif

  rx_peak_window_reader #(.RAM_BASE_ADDRESS(BASE)) dut (
    .crx_clk(clk), .rrx_rst_n(rst_n), .erx_en(en), .ibuff_flag(flag), .ipeak_pos(pos),
    .iram_data_out(rdata), .oram_r_enable(ren), .oram_r_address(raddr), .osample(samp),
    .osample_valid(valid), .isample_ready(ready), .osample_first(first), .osample_last(last),
    .opeak_pos(peak_o), .obusy(busy), .ooverrun(ovr)
`ifdef RX_PEAK_WIN_THRESH_EN
    , .ipeak_val(pval), .ithreshold(thr), .odropped(dropped)
`endif
  );

  always #5 clk = ~clk;

  logic signed [31:0] mem [0:1023];
  always @(posedge clk) if (ren) rdata <= mem[raddr];

  typedef struct {
    int                 addr;
    logic signed [31:0] data;
    bit                 first;
    bit                 last;
    logic [6:0]         peak;
  } exp_t;

  typedef struct {
    logic [6:0] pos;
    bit         rnd;
    int         exp_first;
    int         exp_last;
  } vec_t;

  exp_t               q_samp[$];
  int                 q_addr[$];
  int                 rd_log[$];
  logic signed [31:0] win_samp [0:127];
  int                 n_xfer = 0;
  int                 n_ovr = 0;
  int                 checks = 0;
  int                 failures = 0;
  bit                 rdy_rand = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Reference: window is the completed half read circularly so the peak lands at index 63.
  task automatic model_window(input bit new_flag, input logic [6:0] p);
    int half, start, a;
    exp_t e;
    half  = new_flag ? 0 : 128;
    start = ((int'(p) - 63) % 128 + 128) % 128;
    for (int k = 0; k < 128; k++) begin
      a = BASE + half + ((start + k) % 128);
      q_addr.push_back(a);
      e.addr = a; e.data = mem[a]; e.first = (k == 0); e.last = (k == 127); e.peak = p;
      q_samp.push_back(e);
    end
  endtask

  // Monitor
  bit                 prev_stall = 1'b0;
  bit                 prev_ovr = 1'b0;
  logic signed [31:0] prev_samp;
  bit                 prev_first, prev_last;
  always @(negedge clk) begin
    exp_t e;
    int   a;
    if (rst_n) begin
      if (ren) begin
        chk("read_expected", q_addr.size() > 0, 1);
        if (q_addr.size() > 0) begin
          a = q_addr.pop_front();
          chk("rd_addr", raddr, a);
        end
        rd_log.push_back(int'(raddr));
      end
      if (prev_stall && valid) begin
        chk("stall_sample", samp, prev_samp);
        chk("stall_first", first, prev_first);
        chk("stall_last", last, prev_last);
      end
      if (valid && ready) begin
        chk("xfer_expected", q_samp.size() > 0, 1);
        if (q_samp.size() > 0) begin
          e = q_samp.pop_front();
          chk("sample", samp, e.data);
          chk("first", first, e.first);
          chk("last", last, e.last);
          chk("peak_pos", peak_o, e.peak);
        end
        if (n_xfer < 128) win_samp[n_xfer] = samp;
        n_xfer++;
      end
      if (ovr) begin
        chk("ovr_width", prev_ovr, 0);
        n_ovr++;
      end
`ifdef RX_PEAK_WIN_THRESH_EN
      if (dropped) n_drop++;
`endif
      prev_ovr   = ovr;
      prev_stall = valid && !ready;
      prev_samp  = samp;
      prev_first = first;
      prev_last  = last;
    end
  end

  initial forever begin
    @(posedge clk); #1;
    if (rdy_rand) ready = 1'($urandom % 2);
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic swap(input logic [6:0] p, input bit expect_win);
    @(posedge clk); #1;
    flag = ~flag;
    pos  = p;
    if (expect_win) begin
      rd_log.delete();
      n_xfer = 0;
      model_window(flag, p);
    end
  endtask

  task automatic wait_done(input string name);
    bit done = 1'b0;
    for (int c = 0; c < 3000 && !done; c++) begin
      step(1);
      done = (q_samp.size() == 0) && !busy;
    end
    chk(name, done, 1);
  endtask

  task automatic wait_xfer(input int n, input string name);
    bit hit = 1'b0;
    for (int c = 0; c < 3000 && !hit; c++) begin
      step(1);
      hit = (n_xfer >= n);
    end
    chk(name, hit, 1);
  endtask

  vec_t vt[5];

  initial begin
    bit   hit;
    logic [6:0] p;
    for (int i = 0; i < 1024; i++) mem[i] = $signed($urandom);
    vt[0] = '{7'd70,  1'b0, BASE + 7,   BASE + 6};
    vt[1] = '{7'd10,  1'b0, 459,        458};
    vt[2] = '{7'd63,  1'b1, BASE + 0,   BASE + 127};
    vt[3] = '{7'd0,   1'b1, BASE + 193, BASE + 192};
    vt[4] = '{7'd127, 1'b0, BASE + 64,  BASE + 63};

    #1;
    chk("rst_valid", valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ren", ren, 0);
    chk("rst_addr", raddr, 0);
    chk("rst_sample", samp, 0);
    step(2);
    rst_n = 1'b1;
    step(5);
    chk("idle_busy", busy, 0);
    chk("idle_reads", rd_log.size(), 0);

    foreach (vt[i]) begin
      rdy_rand = vt[i].rnd;
      ready    = 1'b1;
      swap(vt[i].pos, 1'b1);
      wait_done("vec_done");
      chk("vec_xfers", n_xfer, 128);
      chk("vec_reads", rd_log.size(), 128);
      chk("vec_first_addr", rd_log[0], vt[i].exp_first);
      chk("vec_last_addr", rd_log[127], vt[i].exp_last);
      chk("vec_peak_data", win_samp[63], mem[BASE + (flag ? 0 : 128) + int'(vt[i].pos)]);
      chk("vec_busy_low", busy, 0);
      step(3);
    end

    for (int r = 0; r < 4; r++) begin
      rdy_rand = 1'($urandom % 2);
      ready    = 1'b1;
      swap(7'($urandom), 1'b1);
      wait_done("rand_done");
      chk("rand_xfers", n_xfer, 128);
      step(2);
    end

    // Second toggle mid-window
    rdy_rand = 1'b1;
    n_ovr = 0;
    swap(7'($urandom), 1'b1);
    wait_xfer(40, "ovr_reach40");
    p = 7'($urandom);
    swap(p, 1'b0);
    wait_done("ovr_done");
    step(30);
    chk("ovr_count", n_ovr, 1);
    chk("ovr_xfers", n_xfer, 128);
    chk("ovr_no_restart", busy, 0);

    // Toggle coinciding with the final transfer
    rdy_rand = 1'b0;
    ready = 1'b1;
    n_ovr = 0;
    swap(7'd5, 1'b1);
    wait_xfer(127, "fin_reach127");
    ready = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 20 && !hit; c++) begin step(1); hit = valid; end
    chk("fin_last_valid", hit, 1);
    ready = 1'b1;
    flag  = ~flag;
    step(30);
    chk("fin_ovr_count", n_ovr, 1);
    chk("fin_xfers", n_xfer, 128);
    chk("fin_no_restart", busy, 0);

    // Enable drop mid-window
    swap(7'd100, 1'b1);
    wait_xfer(20, "en_reach20");
    en = 1'b0;
    step(1);
    flag = ~flag;
    step(2);
    chk("en_valid", valid, 0);
    chk("en_busy", busy, 0);
    chk("en_first", first, 0);
    q_samp.delete();
    q_addr.delete();
    rd_log.delete();
    en = 1'b1;
    step(20);
    chk("en_no_reads", rd_log.size(), 0);
    chk("en_no_busy", busy, 0);
    swap(7'd33, 1'b1);
    wait_done("en_after_done");
    chk("en_after_xfers", n_xfer, 128);

`ifdef RX_PEAK_WIN_THRESH_EN
    thr = 32'sd1000;
    pval = 32'sd1000;
    n_drop = 0;
    rd_log.delete();
    swap(7'd40, 1'b0);
    step(10);
    chk("thr_drop_pulse", n_drop, 1);
    chk("thr_no_reads", rd_log.size(), 0);
    pval = 32'sd1001;
    swap(7'd40, 1'b1);
    wait_done("thr_done");
    chk("thr_xfers", n_xfer, 128);
    pval = 32'sd2000;
`endif

    // Asynchronous reset mid-window
    swap(7'd90, 1'b1);
    wait_xfer(10, "rst_reach10");
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_ren", ren, 0);
    chk("arst_sample", samp, 0);
    chk("arst_peak", peak_o, 0);
    q_samp.delete();
    q_addr.delete();
    rd_log.delete();
    flag = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(10);
    chk("arst_idle_reads", rd_log.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
